ir_command_scheduler: RTL and testbench



---
 rtl/ir_command_scheduler.sv | 103 ++++++++++
 tb/tb_ir_command_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ir_command_scheduler.sv
// rtl/ir_command_scheduler.sv - fixed-rate IR packet scheduler with switch/bus arbitration
// A period counter paces WAIT->LATCH->FIRE; the command is frozen on entry to FIRE.
module ir_command_scheduler #(
  parameter int PERIOD_MAX   = 9999999,
  parameter int PERIOD_WIDTH = 24,
  parameter int CMD_HOLD     = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic [3:0] SW_CMD,
  input  logic       SW_VALID,
  input  logic [3:0] BUS_CMD,
  input  logic       BUS_WE,
  output logic [3:0] COMMAND,
  output logic       SEND_PACKET,
  output logic [1:0] SOURCE,
  output logic [7:0] PACKET_COUNT
);

  localparam logic [PERIOD_WIDTH-1:0] PMAX = PERIOD_WIDTH'(PERIOD_MAX);
  localparam logic [3:0]              HOLD = 4'(CMD_HOLD);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_LATCH = 2'd1,
    ST_FIRE  = 2'd2
  } state_t;

  state_t                  state;
  logic [PERIOD_WIDTH-1:0] period_cnt;
  logic [3:0]              bus_cmd_r;
  logic [3:0]              hold_cnt;
  logic                    tick;
  logic [3:0]              arb_cmd;
  logic [1:0]              arb_src;

  // Opposing direction pairs cancel; the other pair passes untouched.
  function automatic logic [3:0] sanitise(input logic [3:0] c);
    logic [3:0] r;
    r = c;
    if (c[0] && c[1]) r[1:0] = 2'b00;
    if (c[2] && c[3]) r[3:2] = 2'b00;
    return r;
  endfunction

  assign tick = ENABLE && (period_cnt == PMAX);

  always_comb begin
    arb_cmd = 4'b0000;
    arb_src = 2'b00;
    if (hold_cnt != 4'd0) begin
      arb_cmd = sanitise(bus_cmd_r);
      arb_src = 2'b10;
    end else if (SW_VALID) begin
      arb_cmd = sanitise(SW_CMD);
      arb_src = 2'b01;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET || !ENABLE || period_cnt == PMAX) period_cnt <= '0;
    else                                         period_cnt <= period_cnt + 1'b1;
  end

  // A write in the same cycle as a bus-packet decrement reloads the full hold.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bus_cmd_r <= 4'b0000;
      hold_cnt  <= 4'd0;
    end else if (BUS_WE) begin
      bus_cmd_r <= BUS_CMD;
      hold_cnt  <= HOLD;
    end else if (state == ST_FIRE && SOURCE == 2'b10 && hold_cnt != 4'd0) begin
      hold_cnt  <= hold_cnt - 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= ST_WAIT;
      COMMAND      <= 4'b0000;
      SOURCE       <= 2'b00;
      SEND_PACKET  <= 1'b0;
      PACKET_COUNT <= 8'd0;
    end else begin
      SEND_PACKET <= 1'b0;
      case (state)
        ST_WAIT: if (tick) state <= ST_LATCH;
        ST_LATCH: begin
          COMMAND      <= arb_cmd;
          SOURCE       <= arb_src;
          SEND_PACKET  <= 1'b1;
          PACKET_COUNT <= PACKET_COUNT + 8'd1;
          state        <= ST_FIRE;
        end
        ST_FIRE: state <= ST_WAIT;
        default: state <= ST_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_command_scheduler.sv
// tb/tb_ir_command_scheduler.sv - directed scoreboard bench for ir_command_scheduler
module tb_ir_command_scheduler;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       ENABLE = 1'b0;
  logic [3:0] SW_CMD = 4'b0000;
  logic       SW_VALID = 1'b0;
  logic [3:0] BUS_CMD = 4'b0000;
  logic       BUS_WE = 1'b0;
  logic [3:0] COMMAND;
  logic       SEND_PACKET;
  logic [1:0] SOURCE;
  logic [7:0] PACKET_COUNT;

  ir_command_scheduler #(.PERIOD_MAX(99), .PERIOD_WIDTH(24), .CMD_HOLD(2)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .SW_CMD(SW_CMD), .SW_VALID(SW_VALID),
    .BUS_CMD(BUS_CMD), .BUS_WE(BUS_WE), .COMMAND(COMMAND), .SEND_PACKET(SEND_PACKET),
    .SOURCE(SOURCE), .PACKET_COUNT(PACKET_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] cmd;
    logic [1:0] src;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  int         compared = 0;
  int         mismatched = 0;
  int         cyc = 0;
  int         last_at = 0;
  logic [3:0] last_cmd = 4'b0000;
  logic [7:0] exp_count = 8'd0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] cmd, input logic [1:0] src);
    exp_count = exp_count + 8'd1;
    sb.push_back({cmd, src, exp_count});
  endtask

  // Waits for the next strobe, checking spacing, command stability and the scoreboard.
  task automatic strobe_check(input string tag, input int gap);
    int   at;
    logic stable;
    exp_t e;
    at = -1;
    stable = 1'b1;
    for (int i = 0; i < 250; i++) begin
      @(negedge CLK);
      if (SEND_PACKET) begin
        at = cyc;
        break;
      end
      if (COMMAND !== last_cmd) stable = 1'b0;
    end
    chk({tag, "_gap"}, at - last_at, gap);
    chk({tag, "_stable"}, 32'(stable), 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_cmd"}, 32'(COMMAND), 32'(e.cmd));
      chk({tag, "_src"}, 32'(SOURCE), 32'(e.src));
      chk({tag, "_cnt"}, 32'(PACKET_COUNT), 32'(e.cnt));
    end
    if (at >= 0) last_at = at;
    last_cmd = COMMAND;
  endtask

  initial begin
    int seen;

    // Reset state
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_cmd", 32'(COMMAND), 32'd0);
    chk("rst_send", 32'(SEND_PACKET), 32'd0);
    chk("rst_src", 32'(SOURCE), 32'd0);
    chk("rst_cnt", 32'(PACKET_COUNT), 32'd0);

    // Idle refresh packets after enable
    RESET = 1'b0;
    ENABLE = 1'b1;
    last_at = cyc;
    for (int i = 0; i < 3; i++) push(4'b0000, 2'b00);
    strobe_check("idle1", 101);
    strobe_check("idle2", 100);
    strobe_check("idle3", 100);

    // Switch path
    SW_VALID = 1'b1;
    SW_CMD = 4'b1001;
    push(4'b1001, 2'b01);
    strobe_check("sw", 100);

    // Bus priority then hold expiry back to switch
    SW_CMD = 4'b1000;
    BUS_CMD = 4'b0110;
    BUS_WE = 1'b1;
    @(negedge CLK);
    BUS_WE = 1'b0;
    push(4'b0110, 2'b10);
    push(4'b0110, 2'b10);
    push(4'b1000, 2'b01);
    strobe_check("bus1", 100);
    strobe_check("bus2", 100);
    strobe_check("bus_exp", 100);

    // Write during the FIRE of a bus packet reloads the hold
    BUS_WE = 1'b1;
    @(negedge CLK);
    BUS_WE = 1'b0;
    push(4'b0110, 2'b10);
    strobe_check("rl0", 100);
    BUS_CMD = 4'b0101;
    BUS_WE = 1'b1;
    @(negedge CLK);
    BUS_WE = 1'b0;
    push(4'b0101, 2'b10);
    push(4'b0101, 2'b10);
    push(4'b1000, 2'b01);
    strobe_check("rl1", 100);
    strobe_check("rl2", 100);
    strobe_check("rl_exp", 100);

    // Conflict masking
    SW_CMD = 4'b0111;
    push(4'b0100, 2'b01);
    strobe_check("mask_lr", 100);
    SW_CMD = 4'b1111;
    push(4'b0000, 2'b01);
    strobe_check("mask_all", 100);
    SW_CMD = 4'b1110;
    push(4'b0010, 2'b01);
    strobe_check("mask_fb", 100);

    // Drop enable in the LATCH cycle: the strobe still completes, then silence
    push(4'b0010, 2'b01);
    repeat (99) @(posedge CLK);
    @(negedge CLK);
    ENABLE = 1'b0;
    strobe_check("en_drop", 100);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (SEND_PACKET) seen++;
    end
    chk("no_strobe_disabled", 32'(seen), 32'd0);

    // Reset during LATCH suppresses the strobe and clears outputs
    ENABLE = 1'b1;
    repeat (100) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    chk("rl_send", 32'(SEND_PACKET), 32'd0);
    chk("rl_cmd", 32'(COMMAND), 32'd0);
    chk("rl_src", 32'(SOURCE), 32'd0);
    chk("rl_cnt", 32'(PACKET_COUNT), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Packet counter wrap over 256 idle packets
    RESET = 1'b0;
    SW_VALID = 1'b0;
    exp_count = 8'd0;
    last_cmd = 4'b0000;
    last_at = cyc;
    push(4'b0000, 2'b00);
    strobe_check("wrap_first", 101);
    for (int i = 1; i < 256; i++) begin
      push(4'b0000, 2'b00);
      strobe_check("wrap", 100);
    end
    chk("wrap_zero", 32'(PACKET_COUNT), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
